// File: rtl/seq_pkg.sv
// ============================================================================
//  Module      : seq_pkg
//  Description : Opcodes, FSM state encoding and immediate width shared by
//                the register-file sequencer. Macro SEQ_CMP_EN enables CMP.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_pkg;

    localparam logic [2:0] OP_MOVI = 3'b000;
    localparam logic [2:0] OP_MOV  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_MVN  = 3'b100;
    localparam logic [2:0] OP_CMP  = 3'b101;

    // Immediate width before sign extension to the datapath width
    localparam int IMM_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        EXEC  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } seq_state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
`ifdef SEQ_CMP_EN
        return (op <= OP_CMP);
`else
        return (op < OP_CMP);
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
//  Module      : seq_alu
//  Description : Combinational ALU for the sequencer: result and Z/N/V flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu
    import seq_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [2:0]       op,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    b,
    input  logic [IMM_W-1:0] imm,
    output logic [DW-1:0]    result,
    output logic             z,
    output logic             n,
    output logic             v
);

    always_comb begin
        result = '0;
        v      = 1'b0;
        case (op)
            OP_MOVI: result = {{(DW-IMM_W){imm[IMM_W-1]}}, imm};
            OP_MOV:  result = b;
            OP_ADD: begin
                result = a + b;
                v      = (a[DW-1] == b[DW-1]) && (result[DW-1] != a[DW-1]);
            end
            OP_AND:  result = a & b;
            OP_MVN:  result = ~b;
            OP_CMP: begin
                result = a - b;
                v      = (a[DW-1] != b[DW-1]) && (result[DW-1] != a[DW-1]);
            end
            default: result = '0;
        endcase
        z = (result == '0);
        n = result[DW-1];
    end

endmodule

`default_nettype wire

// File: rtl/regfile_sequencer.sv
// ============================================================================
//  Module      : regfile_sequencer
//  Description : Command-driven initiator that reads operands from the 8x16
//                register file, executes, and writes back. SEQ_CMP_EN adds CMP.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sequencer
    import seq_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_rn,
    input  logic [AW-1:0]    cmd_rm,
    input  logic [IMM_W-1:0] cmd_imm,
    output logic [AW-1:0]    rf_readnum,
    input  logic [DW-1:0]    rf_data_out,
    output logic [AW-1:0]    rf_writenum,
    output logic             rf_write,
    output logic [DW-1:0]    rf_data_in,
    output logic             done,
    output logic             err,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_v
);

    seq_state_t       r_state;
    seq_state_t       w_next;
    logic [2:0]       r_op;
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_rn;
    logic [AW-1:0]    r_rm;
    logic [IMM_W-1:0] r_imm;
    logic             r_illegal;
    logic [DW-1:0]    r_a;
    logic [DW-1:0]    r_b;
    logic [DW-1:0]    r_c;
    logic [AW-1:0]    r_wnum;
    logic             r_z;
    logic             r_n;
    logic             r_v;
    logic [DW-1:0]    w_result;
    logic             w_z;
    logic             w_n;
    logic             w_v;

    seq_alu #(.DW(DW)) u_alu (
        .op     (r_op),
        .a      (r_a),
        .b      (r_b),
        .imm    (r_imm),
        .result (w_result),
        .z      (w_z),
        .n      (w_n),
        .v      (w_v)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (cmd_valid) begin
                    if (!op_is_legal(cmd_op))
                        w_next = DONE;
                    else if (cmd_op == OP_MOVI)
                        w_next = EXEC;
                    else if (cmd_op == OP_MOV || cmd_op == OP_MVN)
                        w_next = RD_B;
                    else
                        w_next = RD_A;
                end
            end
            RD_A:    w_next = RD_B;
            RD_B:    w_next = EXEC;
            EXEC:    w_next = (r_op == OP_CMP) ? DONE : WRITE;
            WRITE:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_op      <= '0;
            r_rd      <= '0;
            r_rn      <= '0;
            r_rm      <= '0;
            r_imm     <= '0;
            r_illegal <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_wnum    <= '0;
            r_z       <= 1'b0;
            r_n       <= 1'b0;
            r_v       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && cmd_valid) begin
                r_op      <= cmd_op;
                r_rd      <= cmd_rd;
                r_rn      <= cmd_rn;
                r_rm      <= cmd_rm;
                r_imm     <= cmd_imm;
                r_illegal <= !op_is_legal(cmd_op);
            end
            if (r_state == RD_A)
                r_a <= rf_data_out;
            if (r_state == RD_B)
                r_b <= rf_data_out;
            if (r_state == EXEC) begin
                // CMP only touches flags, so the write-back registers keep
                // presenting the previous write
                if (r_op != OP_CMP) begin
                    r_c    <= w_result;
                    r_wnum <= r_rd;
                end
                if (r_op == OP_ADD || r_op == OP_CMP) begin
                    r_z <= w_z;
                    r_n <= w_n;
                    r_v <= w_v;
                end
            end
        end
    end

    always_comb begin
        rf_readnum = '0;
        if (r_state == RD_A)
            rf_readnum = r_rn;
        else if (r_state == RD_B)
            rf_readnum = r_rm;
    end

    assign cmd_ready   = (r_state == IDLE);
    assign rf_write    = (r_state == WRITE);
    assign rf_writenum = r_wnum;
    assign rf_data_in  = r_c;
    assign done        = (r_state == DONE);
    assign err         = done & r_illegal;
    assign flag_z      = r_z;
    assign flag_n      = r_n;
    assign flag_v      = r_v;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sequencer.sv
// ============================================================================
//  Module      : tb_regfile_sequencer
//  Description : Directed-vector bench for regfile_sequencer with an 8x16
//                register file model. SEQ_CMP_EN selects the CMP expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [2:0]  cmd_rd = '0;
    logic [2:0]  cmd_rn = '0;
    logic [2:0]  cmd_rm = '0;
    logic [7:0]  cmd_imm = '0;
    logic [2:0]  rf_readnum;
    logic [15:0] rf_data_out;
    logic [2:0]  rf_writenum;
    logic        rf_write;
    logic [15:0] rf_data_in;
    logic        done;
    logic        err;
    logic        flag_z;
    logic        flag_n;
    logic        flag_v;

    logic [15:0] rf [8];
    logic        preload = 1'b0;

    int n_vec  = 0;
    int n_fail = 0;

    regfile_sequencer #(.DW(16), .AW(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_rd      (cmd_rd),
        .cmd_rn      (cmd_rn),
        .cmd_rm      (cmd_rm),
        .cmd_imm     (cmd_imm),
        .rf_readnum  (rf_readnum),
        .rf_data_out (rf_data_out),
        .rf_writenum (rf_writenum),
        .rf_write    (rf_write),
        .rf_data_in  (rf_data_in),
        .done        (done),
        .err         (err),
        .flag_z      (flag_z),
        .flag_n      (flag_n),
        .flag_v      (flag_v)
    );

    always #5 clk = ~clk;

    assign rf_data_out = rf[rf_readnum];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
            rf[1] <= 16'h7FFF;
            rf[2] <= 16'h0001;
            rf[5] <= 16'h1234;
        end else if (rf_write) begin
            rf[rf_writenum] <= rf_data_in;
        end
    end

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rn;
        logic [2:0]  rm;
        logic [7:0]  imm;
        int          lat;
        int          nwr;
        logic [15:0] wdata;
        logic        err;
        logic [2:0]  flags;  // {z, n, v}
        logic [2:0]  rs0;
        logic [2:0]  rs1;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one command and watches it to completion; lat = -1 on timeout
    task automatic run_cmd(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rn,
                           input logic [2:0] rm, input logic [7:0] imm,
                           output int lat, output int nwr, output logic [2:0] wnum,
                           output logic [15:0] wdata, output logic err_o,
                           output logic [2:0] rs0, output logic [2:0] rs1);
        lat = -1; nwr = 0; wnum = '0; wdata = '0; err_o = 1'b0; rs0 = '0; rs1 = '0;
        @(negedge clk);
        cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_imm = imm;
        cmd_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (k == 1) rs0 = rf_readnum;
            if (k == 2) rs1 = rf_readnum;
            if (rf_write) begin
                nwr++;
                wnum  = rf_writenum;
                wdata = rf_data_in;
            end
            if (done) begin
                lat   = k;
                err_o = err;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        int          nwr;
        int          ndone;
        int          nready;
        int          cyc;
        int          idx;
        logic        prev_done;
        logic [2:0]  wnum;
        logic [15:0] wdata;
        logic        e;
        logic [2:0]  rs0;
        logic [2:0]  rs1;
        logic [2:0]  b_op [4];
        logic [2:0]  b_rd [4];
        logic [2:0]  b_rn [4];
        logic [2:0]  b_rm [4];
        logic [7:0]  b_imm [4];

        //            op      rd    rn    rm    imm    lat nwr wdata     err   znv     rs0   rs1
        vecs[0]  = '{3'b000, 3'd3, 3'd0, 3'd0, 8'hF6, 3, 1, 16'hFFF6, 1'b0, 3'b000, 3'd0, 3'd0};
        vecs[1]  = '{3'b010, 3'd4, 3'd1, 3'd2, 8'h00, 5, 1, 16'h8000, 1'b0, 3'b011, 3'd1, 3'd2};
        vecs[2]  = '{3'b001, 3'd6, 3'd0, 3'd4, 8'h00, 4, 1, 16'h8000, 1'b0, 3'b011, 3'd4, 3'd0};
        vecs[3]  = '{3'b011, 3'd7, 3'd3, 3'd1, 8'h00, 5, 1, 16'h7FF6, 1'b0, 3'b011, 3'd3, 3'd1};
        vecs[4]  = '{3'b100, 3'd2, 3'd0, 3'd2, 8'h00, 4, 1, 16'hFFFE, 1'b0, 3'b011, 3'd2, 3'd0};
        vecs[5]  = '{3'b000, 3'd0, 3'd0, 3'd0, 8'h0A, 3, 1, 16'h000A, 1'b0, 3'b011, 3'd0, 3'd0};
        vecs[6]  = '{3'b010, 3'd5, 3'd3, 3'd0, 8'h00, 5, 1, 16'h0000, 1'b0, 3'b100, 3'd3, 3'd0};
        vecs[7]  = '{3'b111, 3'd6, 3'd1, 3'd2, 8'h00, 1, 0, 16'h0000, 1'b1, 3'b100, 3'd0, 3'd0};
        vecs[8]  = '{3'b010, 3'd6, 3'd1, 3'd0, 8'h00, 5, 1, 16'h8009, 1'b0, 3'b011, 3'd1, 3'd0};
`ifdef SEQ_CMP_EN
        vecs[9]  = '{3'b101, 3'd7, 3'd5, 3'd5, 8'h00, 4, 0, 16'h0000, 1'b0, 3'b100, 3'd5, 3'd5};
        vecs[10] = '{3'b110, 3'd7, 3'd0, 3'd0, 8'h00, 1, 0, 16'h0000, 1'b1, 3'b100, 3'd0, 3'd0};
        vecs[11] = '{3'b100, 3'd1, 3'd0, 3'd5, 8'h00, 4, 1, 16'hFFFF, 1'b0, 3'b100, 3'd5, 3'd0};
`else
        vecs[9]  = '{3'b101, 3'd7, 3'd5, 3'd5, 8'h00, 1, 0, 16'h0000, 1'b1, 3'b011, 3'd0, 3'd0};
        vecs[10] = '{3'b110, 3'd7, 3'd0, 3'd0, 8'h00, 1, 0, 16'h0000, 1'b1, 3'b011, 3'd0, 3'd0};
        vecs[11] = '{3'b100, 3'd1, 3'd0, 3'd5, 8'h00, 4, 1, 16'hFFFF, 1'b0, 3'b011, 3'd5, 3'd0};
`endif

        // Reset state
        preload = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        preload = 1'b0;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_rf_write", {31'd0, rf_write}, 32'd0);
        check("rst_done_err", {30'd0, done, err}, 32'd0);
        check("rst_flags", {29'd0, flag_z, flag_n, flag_v}, 32'd0);
        check("rst_readnum", {29'd0, rf_readnum}, 32'd0);
        check("rst_wr_regs", {13'd0, rf_writenum, rf_data_in}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_cmd(vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm,
                    lat, nwr, wnum, wdata, e, rs0, rs1);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_write_count", i), nwr, vecs[i].nwr);
            check($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vecs[i].err});
            check($sformatf("v%0d_flags", i), {29'd0, flag_z, flag_n, flag_v}, {29'd0, vecs[i].flags});
            check($sformatf("v%0d_readnum0", i), {29'd0, rs0}, {29'd0, vecs[i].rs0});
            check($sformatf("v%0d_readnum1", i), {29'd0, rs1}, {29'd0, vecs[i].rs1});
            if (vecs[i].nwr > 0) begin
                check($sformatf("v%0d_writenum", i), {29'd0, wnum}, {29'd0, vecs[i].rd});
                check($sformatf("v%0d_wdata", i), {16'd0, wdata}, {16'd0, vecs[i].wdata});
            end
        end

        // Reset asserted in the WRITE cycle of an ADD: R4 must keep 16'h8000
        @(negedge clk);
        cmd_op = 3'b010; cmd_rd = 3'd4; cmd_rn = 3'd1; cmd_rm = 3'd2; cmd_valid = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (rf_write) begin
                lat = k;
                break;
            end
        end
        check("midrst_reach_write", lat, 4);
        rst_n = 1'b0;
        #1;
        check("midrst_write_drop", {31'd0, rf_write}, 32'd0);
        check("midrst_flags", {29'd0, flag_z, flag_n, flag_v}, 32'd0);
        ndone = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) ndone++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        check("midrst_ready", {31'd0, cmd_ready}, 32'd1);
        check("midrst_r4_kept", {16'd0, rf[4]}, 32'h0000_8000);

        // Back-to-back commands with cmd_valid held high
        b_op[0] = 3'b000; b_rd[0] = 3'd1; b_rn[0] = 3'd0; b_rm[0] = 3'd0; b_imm[0] = 8'h7F;
        b_op[1] = 3'b111; b_rd[1] = 3'd2; b_rn[1] = 3'd0; b_rm[1] = 3'd0; b_imm[1] = 8'h00;
        b_op[2] = 3'b001; b_rd[2] = 3'd2; b_rn[2] = 3'd0; b_rm[2] = 3'd1; b_imm[2] = 8'h00;
        b_op[3] = 3'b010; b_rd[3] = 3'd3; b_rn[3] = 3'd1; b_rm[3] = 3'd2; b_imm[3] = 8'h00;
        @(negedge clk);
        idx = 0;
        cmd_op = b_op[0]; cmd_rd = b_rd[0]; cmd_rn = b_rn[0]; cmd_rm = b_rm[0]; cmd_imm = b_imm[0];
        cmd_valid = 1'b1;
        ndone = 0; nwr = 0; nready = 0; cyc = 0; prev_done = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            cyc = c;
            if (prev_done)
                check($sformatf("b2b_ready_after_done%0d", ndone), {31'd0, cmd_ready}, 32'd1);
            if (cmd_ready) nready++;
            if (rf_write) nwr++;
            prev_done = done;
            if (done) begin
                ndone++;
                idx++;
                if (idx < 4) begin
                    cmd_op = b_op[idx]; cmd_rd = b_rd[idx]; cmd_rn = b_rn[idx];
                    cmd_rm = b_rm[idx]; cmd_imm = b_imm[idx];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (ndone == 4) break;
        end
        cmd_valid = 1'b0;
        check("b2b_done_count", ndone, 4);
        check("b2b_write_count", nwr, 3);
        check("b2b_ready_count", nready, 3);
        check("b2b_cycles", cyc, 16);
        check("b2b_r3_result", {16'd0, rf[3]}, 32'h0000_00FE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Command-driven initiator for the 8x16 register file. Accepts one register-transfer command per handshake and sequences the register file's readnum, writenum, write and data_in ports.
- Captures operands from the register file's combinational data_out, computes a result and writes it back.
- Sits between the instruction decode path and the register file.

Parameters:
- DW, 16, datapath width (must match the register file).
- AW, 3, register address width (8 registers).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  opcode.
- cmd_rd  in  AW  destination register.
- cmd_rn  in  AW  first source register.
- cmd_rm  in  AW  second source register.
- cmd_imm  in  8  immediate, sign-extended to DW.
- rf_readnum  out  AW  register file read select.
- rf_data_out  in  DW  register file read data (combinational).
- rf_writenum  out  AW  register file write select.
- rf_write  out  1  register file write enable.
- rf_data_in  out  DW  register file write data.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid together with done: command was illegal.
- flag_z, flag_n, flag_v  out  1 each  status flags.

Behaviour:
- Opcodes:
  - 000 MOVI: Rd = sext(imm).
  - 001 MOV: Rd = Rm.
  - 010 ADD: Rd = Rn + Rm.
  - 011 AND: Rd = Rn & Rm.
  - 100 MVN: Rd = ~Rm.
  - 101 CMP: optional, see below.
  - 110 and 111: illegal.
- States: IDLE, RD_A, RD_B, EXEC, WRITE, DONE.
- Handshake:
  - cmd_ready = 1 only in IDLE.
  - A command is accepted on a clk edge where cmd_valid & cmd_ready; all cmd_* fields are latched on that edge.
  - cmd_valid while not ready is ignored; no queueing.
- Transitions from IDLE on accept:
  - MOVI goes to EXEC.
  - MOV and MVN go to RD_B.
  - ADD, AND and CMP go to RD_A.
  - Illegal opcodes go to DONE.
- Read and execute states:
  - RD_A: rf_readnum = rn; A <= rf_data_out; next state RD_B.
  - RD_B: rf_readnum = rm; B <= rf_data_out; next state EXEC.
  - EXEC: C <= result; flags update; next state WRITE (DONE for CMP).
- WRITE (exactly one cycle):
  - rf_write = 1, rf_writenum = rd, rf_data_in = C.
  - Next state DONE.
- DONE: done = 1 for one cycle; err = 1 if the opcode was illegal; next state IDLE.
- Latency from accept edge to done: MOVI 3 cycles; MOV/MVN 4; ADD/AND 5; illegal 1.
- Outside the RD_A/RD_B states, rf_readnum = 0. Outside WRITE, rf_write = 0 and rf_writenum/rf_data_in hold their last values.
- Arithmetic: all operations are DW-bit and wrap modulo 2^DW. ADD carry-out is discarded.
- Flags are updated only by ADD and CMP, in EXEC:
  - Z = (result == 0).
  - N = result[DW-1].
  - V = signed overflow.
  - MOVI/MOV/AND/MVN leave the flags unchanged.
- Rd may equal Rn or Rm. Operands are captured before WRITE, so no hazard exists.
- Reset:
  - Asynchronous assert forces IDLE and clears A, B, C, flags, done and err.
  - rf_write goes to 0 immediately, including mid-WRITE.
  - A command in flight is dropped and no done is produced.
  - cmd_ready = 1 after reset deasserts.
- All outputs decode from registered state; no combinational path from cmd_* to rf_*.

Optional Feature:
- Macro SEQ_CMP_EN.
- Defined: opcode 101 CMP computes A - B and updates Z/N/V (V = signed subtract overflow). The path is RD_A, RD_B, EXEC, DONE (latency 4); no WRITE cycle and rf_write is never asserted.
- Undefined: 101 is illegal and completes with err = 1 after 1 cycle.

Decomposition:
- Package seq_pkg:
  - Opcode localparams: OP_MOVI, OP_MOV, OP_ADD, OP_AND, OP_MVN, OP_CMP.
  - State encoding typedef: IDLE, RD_A, RD_B, EXEC, WRITE, DONE.
  - Sign-extend width constant.
- Sub-module seq_alu: combinational; inputs op, A, B, imm; outputs result, z, n, v. The sequencer owns the FSM and operand/result registers.

Test Plan:
- Reset, then MOVI rd=3 imm=8'hF6 -> rf_write pulses once 2 cycles after accept; writenum=3, data_in=16'hFFF6; done 1 cycle later; err=0.
- With R1=16'h7FFF and R2=16'h0001 preloaded, ADD rd=4 rn=1 rm=2 -> readnum=1 then 2; write R4=16'h8000; N=1, V=1, Z=0; done at accept+5.
- MVN rd=2 rm=2 with R2=16'h00FF -> writes 16'hFF00 to R2; flags unchanged from the prior value.
- cmd_op=3'b111 -> done and err together 1 cycle after accept; rf_write never asserted. Re-run with SEQ_CMP_EN on CMP R5=R5 -> Z=1, no write, done at +4; with the macro off, op 101 gives err=1.
- Assert rst_n=0 during the WRITE state of an ADD -> rf_write drops before the next edge; no done; cmd_ready=1 after release; flags are 0.
- Hold cmd_valid high with back-to-back commands -> the second command is accepted only on the cycle after done; rf_write count equals the number of legal non-CMP commands.
